mult_div_unit: RTL
==================

# mult_div_unit

- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the execute stage and serves MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- The control path reads results through `hi`/`lo` (MFHI/MFLO) and stalls the PC while `busy` is high.
- Operands come from the register file read ports (rs → `a`, rt → `b`).

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits. Legal values are 4 or more.
- `clk` input, 1 bit: clock. Every state element updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request a new operation. Sampled on a rising edge only while `busy`=0.
- `op` input, 3 bits: operation select.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are ignored: no state change and no `done`.
- `a` input, `WIDTH` bits: multiplicand or dividend; also the source for MTHI/MTLO.
- `b` input, `WIDTH` bits: multiplier or divisor.
- `busy` output, 1 bit: an operation is in progress. New `start` requests are ignored while it is high.
- `done` output, 1 bit: one-cycle pulse marking the cycle in which `hi`/`lo` first show the new result.
- `divzero` output, 1 bit: valid only while `done`=1. High when a DIV or DIVU had `b`=0.
- `hi` output, `WIDTH` bits: HI register. Holds its value until the next write.
- `lo` output, `WIDTH` bits: LO register. Holds its value until the next write.

## Operation
States:
- **IDLE**
  - `start`=1 with MULT/MULTU/DIV/DIVU:
    - latch operand magnitudes (absolute values for signed ops, raw values for unsigned ops);
    - latch the result signs: product sign is `a[W-1]^b[W-1]`; remainder sign is `a[W-1]`;
    - clear the iteration counter and go to RUN.
  - DIV/DIVU with `b`=0: go directly to FIX with the div-by-zero flag set.
  - MTHI/MTLO: write `hi`/`lo` from `a` at this edge, pulse `done` next cycle, stay in IDLE.
- **RUN**
  - Executes one iteration per cycle for exactly `WIDTH` cycles; the counter is `$clog2(WIDTH)+1` bits.
  - Multiply: radix-2 shift-add into a 2·`WIDTH` accumulator.
  - Divide: restoring shift-subtract, producing a `WIDTH`-bit quotient and a `WIDTH`-bit remainder.
  - After the last iteration, go to FIX.
- **FIX**
  - Applies sign correction (two's-complement negate where the latched sign says so).
  - Writes `hi`/`lo`, pulses `done`, returns to IDLE.

Result rules:
- Multiply: `hi` = product[2W-1:W], `lo` = product[W-1:0]. Signed multiply gives the exact 2W-bit two's-complement product.
- Divide: `lo` = quotient truncated toward zero; `hi` = remainder, which takes the sign of the dividend.
- Divide by zero: `hi` = `a`, `lo` = all ones, `divzero`=1 with `done`. Same behaviour for signed and unsigned.
- DIV of most-negative by −1: `lo` = most-negative, `hi` = 0. This is the natural wrap; no flag is raised.

Boundary conditions:
- `start` while `busy`=1 is ignored. Operands need not be held stable after the accepted `start` edge.
- `reset` at any point, including mid-RUN: next state is IDLE, `hi`=`lo`=0, `busy`=`done`=`divzero`=0. The aborted operation produces no `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `divzero`=0, `hi`=0, `lo`=0, state IDLE.
- Cycle numbering: edge E0 accepts `start`.
- MULT/MULTU/DIV/DIVU with `b`≠0:
  - `busy` is high from after E0 through E`WIDTH+1`;
  - `hi`/`lo` update at E`WIDTH+1`;
  - `done` is high for the single cycle after E`WIDTH+1`, and `busy` is already 0 in that cycle.
  - Total latency is `WIDTH+1` cycles.
- Div-by-zero:
  - FIX at E1, `busy` high for one cycle;
  - `done` and `divzero` are high in the cycle after E1.
- MTHI/MTLO: register written at E0; `done` is high in the cycle after E0; `busy` never rises.
- Back-to-back: a `start` in the same cycle as `done` is accepted, because `busy`=0 in that cycle.
- `hi`/`lo` are registered outputs with no combinational path from the inputs.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - MULT/MULTU skip RUN. IDLE computes the full 2W-bit product with a single-cycle multiplier and goes straight to FIX.
  - `hi`/`lo` update at E1, `done` is high after E1, latency is 1.
  - Division is unchanged.
- `MDU_FAST_MUL_EN` undefined: all multiplies use the iterative `WIDTH+1`-cycle path described above.

## Test plan
(All scenarios at `WIDTH`=32.)
- MULTU `a`=0xFFFFFFFF, `b`=2 → `hi`=0x00000001, `lo`=0xFFFFFFFE. `done` exactly 33 cycles after E0 (1 cycle with `MDU_FAST_MUL_EN`).
- MULT `a`=−3, `b`=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Then MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
- DIV `a`=−7, `b`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU `a`=7, `b`=2 → `lo`=3, `hi`=1. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU `a`=5, `b`=0 → `divzero`=1 with `done` one cycle after E0, `hi`=5, `lo`=0xFFFFFFFF.
- Start a DIVU, pulse `start` with MTHI at cycle 5 → ignored, `hi` unchanged. Assert `reset` at cycle 10 → `busy`=0, `hi`=`lo`=0 in the next cycle, and no `done` ever appears.
- MTHI `a`=0x1234 then MTLO `a`=0xBEEF on consecutive cycles → `hi`=0x1234, `lo`=0xBEEF, each with a `done` pulse and `busy` never high.

Source files
------------

// File: rtl/mult_div_if.sv
// -----------------------------------------------------------------------------
// mult_div_if
//   Request/result bundle between the execute-stage control path and the
//   multiply/divide unit.
//
//   Parameter:
//     WIDTH   operand width (HI and LO are each WIDTH bits)
//
//   Signals:
//     start    request a new operation (honoured only while busy = 0)
//     op       operation select: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//              100 MTHI, 101 MTLO, 110/111 ignored
//     a        multiplicand / dividend / MTHI-MTLO source (rs)
//     b        multiplier / divisor (rt)
//     busy     operation in progress, new requests ignored
//     done     one-cycle pulse: hi/lo show the new result this cycle
//     divzero  qualified by done: the divide had a zero divisor
//     hi, lo   architectural HI/LO registers
//
//   Modports:
//     master   the requester (control path)
//     slave    the multiply/divide unit
// -----------------------------------------------------------------------------
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             divzero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, divzero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, divzero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply/divide unit with architectural HI/LO registers.
//   Serves MULT, MULTU, DIV, DIVU, MTHI and MTLO.
//
//   Multiply: radix-2 shift-add over WIDTH cycles on operand magnitudes.
//   Divide:   restoring shift-subtract over WIDTH cycles on magnitudes.
//   A final FIX cycle applies two's-complement sign correction and writes
//   HI/LO, so a full operation takes WIDTH+1 cycles from the accepting edge.
//
//   Configuration macro:
//     MDU_FAST_MUL_EN  when defined, MULT/MULTU use a single-cycle multiplier
//                      and go straight from IDLE to FIX (latency 1).
//                      Division is unaffected.
//
//   Ports:
//     clk    clock, rising edge
//     reset  synchronous, active-high reset
//     bus    mult_div_if.slave (start/op/a/b in, busy/done/divzero/hi/lo out)
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  mult_div_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  // Shared working register:
  //   multiply: {partial product high, multiplier being shifted out}
  //   divide:   {partial remainder, dividend shifting into quotient}
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   dvd_raw;    // raw dividend, returned in HI on divide-by-zero
  logic               is_div;
  logic               div_zero;
  logic               neg_q;      // negate product / quotient in FIX
  logic               neg_r;      // negate remainder in FIX

  logic               busy_q;
  logic               done_q;
  logic               divzero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic               signed_op;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     shifted;
  logic               fits;
  logic [WIDTH-1:0]   sub;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    mag_a     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Shift-add step: conditionally add the multiplicand to the upper half,
    // then shift the whole accumulator right by one (carry enters the top).
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {add_sum, acc[WIDTH-1:1]};

    // Restoring step: bring the next dividend bit into the remainder and
    // subtract the divisor if it fits. The remainder is always below the
    // divisor afterwards, so the WIDTH-bit modular difference is exact.
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    fits     = (shifted >= {1'b0, opnd});
    sub      = shifted[WIDTH-1:0] - opnd;
    div_next = {(fits ? sub : shifted[WIDTH-1:0]), acc[WIDTH-2:0], fits};

    prod_fix = neg_q ? -acc : acc;

    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (div_zero) begin
      res_hi = dvd_raw;
      res_lo = '1;
    end else if (is_div) begin
      res_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      res_lo = neg_q ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
    end

`ifdef MDU_FAST_MUL_EN
    fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif
  end

  // ---------------------------------------------------------------------------
  // Control FSM and registers
  // ---------------------------------------------------------------------------
  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      dvd_raw   <= '0;
      is_div    <= 1'b0;
      div_zero  <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q    <= 1'b0;
      divzero_q <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                opnd     <= mag_b;
                is_div   <= 1'b0;
                div_zero <= 1'b0;
                neg_q    <= signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_r    <= 1'b0;
                cnt      <= '0;
                busy_q   <= 1'b1;
`ifdef MDU_FAST_MUL_EN
                acc      <= fast_prod;
                state    <= S_FIX;
`else
                acc      <= {{WIDTH{1'b0}}, mag_a};
                state    <= S_RUN;
`endif
              end
              OP_DIV, OP_DIVU: begin
                opnd     <= mag_b;
                acc      <= {{WIDTH{1'b0}}, mag_a};
                dvd_raw  <= bus.a;
                is_div   <= 1'b1;
                div_zero <= (bus.b == '0);
                neg_q    <= signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_r    <= signed_op & bus.a[WIDTH-1];
                cnt      <= '0;
                busy_q   <= 1'b1;
                state    <= (bus.b == '0) ? S_FIX : S_RUN;
              end
              OP_MTHI: begin
                hi_q   <= bus.a;
                done_q <= 1'b1;
              end
              OP_MTLO: begin
                lo_q   <= bus.a;
                done_q <= 1'b1;
              end
              default: ; // 110/111: no state change, no done
            endcase
          end
        end

        S_RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end

        S_FIX: begin
          hi_q      <= res_hi;
          lo_q      <= res_lo;
          done_q    <= 1'b1;
          divzero_q <= div_zero;
          busy_q    <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.divzero = divzero_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule
